// File: rtl/fir_out_requant_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_out_requant_pkg
// Purpose  : Shared width constants, clip limits and the shift-and-saturate
//            helper used on the output side of the FIR tap chain.
// Contents : ACC_W, SAMPLE_W      - accumulator / sample widths
//            SAT_MAX, SAT_MIN     - 16-bit clip limits
//            sat_result_t         - {saturated flag, clipped value}
//            sat_shift()          - arithmetic shift + clip to out_w bits
// Revision : 1.0 - initial release
// ============================================================================
package fir_out_requant_pkg;

    localparam int ACC_W    = 32;
    localparam int SAMPLE_W = 16;

    localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

    // value is the clipped result sign-extended to ACC_W+1 bits; callers
    // keep the low out_w bits.
    typedef struct packed {
        logic             sat;
        logic [ACC_W:0]   value;
    } sat_result_t;

    // Arithmetic right shift followed by a clip to the signed range of an
    // out_w-bit sample. Works for any out_w up to ACC_W.
    function automatic sat_result_t sat_shift(
        input logic signed [ACC_W:0] r,
        input int unsigned           shift,
        input int unsigned           out_w
    );
        sat_result_t           res;
        logic signed [ACC_W:0] one;
        logic signed [ACC_W:0] q;
        logic signed [ACC_W:0] hi;
        logic signed [ACC_W:0] lo;
        one = {{ACC_W{1'b0}}, 1'b1};
        q   = r >>> shift;
        hi  = (one <<< (out_w - 1)) - one;
        lo  = -(one <<< (out_w - 1));
        res.sat   = 1'b0;
        res.value = q;
        if (q > hi) begin
            res.sat   = 1'b1;
            res.value = hi;
        end else if (q < lo) begin
            res.sat   = 1'b1;
            res.value = lo;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fir_sample_fifo
// Purpose  : Synchronous circular-buffer FIFO. Pointers carry one extra MSB
//            so full and empty are told apart by comparing that bit.
// Ports    : clk, rst        - clock, async active-high reset (pointers only)
//            i_push/i_push_data - write request and data
//            i_pop           - read request (ignored while empty)
//            o_pop_data      - head entry
//            o_full/o_empty  - occupancy flags
//            o_level         - number of stored entries
// Revision : 1.0 - initial release
// ============================================================================
module fir_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int c_aw = $clog2(DEPTH);

    logic [c_aw:0]      r_wr_ptr;
    logic [c_aw:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_pop;
    logic               w_push;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign o_level = r_wr_ptr - r_rd_ptr;

    assign w_pop  = i_pop && !o_empty;
    // A write into a full FIFO is accepted when the head leaves on the same
    // edge: it lands in the slot being vacated.
    assign w_push = i_push && (!o_full || w_pop);

    assign o_pop_data = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= i_push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_out_requant.sv
`default_nettype none
// ============================================================================
// Module   : fir_out_requant
// Purpose  : Output-side reader for the FIR tap chain. Rounds (half-up),
//            shifts and saturates each accumulator sample, then buffers it
//            in a FIFO read via valid/ready. The FIR chain cannot be stalled,
//            so writes into a full FIFO are dropped and counted.
// Ports    : clk, reset              - clock, async active-high reset
//            in_valid, in_data       - accumulator stream (signed, IN_W)
//            out_valid, out_data, out_ready - sample handshake (signed, OUT_W)
//            level                   - FIFO occupancy
//            sat_cnt, drop_cnt       - saturating event counters
//            ovf_sticky              - any saturation or drop seen
//            clr_stats               - sync clear of counters and sticky flag
// Revision : 1.0 - initial release
// ============================================================================
module fir_out_requant
    import fir_out_requant_pkg::*;
#(
    parameter int IN_W  = ACC_W,
    parameter int OUT_W = SAMPLE_W,
    parameter int SHIFT = 7,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [IN_W-1:0]          in_data,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         sat_cnt,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     ovf_sticky,
    input  logic                     clr_stats
);

    // Half an output LSB, added before the shift for round-half-up.
    localparam int                     c_rnd_pos = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [IN_W:0]   c_rnd     = (SHIFT > 0) ? ((IN_W+1)'(1) << c_rnd_pos) : '0;

    // ---- stage 1: rounding add, one guard bit so it cannot overflow ----
    logic signed [IN_W:0]   w_in_ext;
    logic                   r_s1_valid;
    logic signed [IN_W:0]   r_acc;

    assign w_in_ext = {in_data[IN_W-1], in_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_acc      <= '0;
        end else begin
            r_s1_valid <= in_valid;
            r_acc      <= w_in_ext + c_rnd;
        end
    end

    // ---- stage 2: shift and clip ----
    logic signed [ACC_W:0]  w_r_ext;
    sat_result_t            w_res;
    logic                   w_unused_hi;
    logic                   r_s2_valid;
    logic                   r_s2_sat;
    logic [OUT_W-1:0]       r_s2_data;

    assign w_r_ext     = (ACC_W+1)'(r_acc);
    assign w_res       = sat_shift(w_r_ext, SHIFT, OUT_W);
    // Bits above the sample are pure sign extension after the clip.
    assign w_unused_hi = ^w_res.value[ACC_W:OUT_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_sat   <= 1'b0;
            r_s2_data  <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_sat   <= r_s1_valid && w_res.sat;
            r_s2_data  <= w_res.value[OUT_W-1:0];
        end
    end

    // ---- FIFO and drop detection ----
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_drop;
    logic w_sat_evt;

    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;
    assign w_drop    = r_s2_valid && w_full && !w_pop;
    // Saturation is counted when the sample reaches the FIFO, dropped or not.
    assign w_sat_evt = r_s2_valid && r_s2_sat;

    fir_sample_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (r_s2_valid),
        .i_push_data (r_s2_data),
        .i_pop       (out_ready),
        .o_pop_data  (out_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (level)
    );

    // ---- statistics: clear wins over increment, counters stick at max ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_cnt    <= '0;
            drop_cnt   <= '0;
            ovf_sticky <= 1'b0;
        end else if (clr_stats) begin
            sat_cnt    <= '0;
            drop_cnt   <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (w_sat_evt && (sat_cnt != '1))  sat_cnt  <= sat_cnt + 1'b1;
            if (w_drop && (drop_cnt != '1))    drop_cnt <= drop_cnt + 1'b1;
            if (w_sat_evt || w_drop)           ovf_sticky <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_out_requant.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_out_requant
// Purpose  : Self-checking bench for fir_out_requant (SHIFT=7, DEPTH=8).
//            A queue-based model tracks expected FIFO contents and counters;
//            directed sequences add hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_out_requant;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic [3:0]  level;
    logic [15:0] sat_cnt;
    logic [15:0] drop_cnt;
    logic        ovf_sticky;
    logic        clr_stats;

    int n_total = 0;
    int n_bad   = 0;

    fir_out_requant dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .level      (level),
        .sat_cnt    (sat_cnt),
        .drop_cnt   (drop_cnt),
        .ovf_sticky (ovf_sticky),
        .clr_stats  (clr_stats)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---- behavioural model ----
    // Expected sample: floor((x + 64) / 128) clipped to int16; bit 16 = clipped.
    function automatic logic [16:0] model_sample(input logic [31:0] x);
        longint v;
        v = (longint'($signed(x)) + 64) >>> 7;
        if (v > 32767)  return {1'b1, 16'h7FFF};
        if (v < -32768) return {1'b1, 16'h8000};
        return {1'b0, v[15:0]};
    endfunction

    logic [15:0] mq[$];
    int          m_sat, m_drop;
    bit          m_ovf;
    bit          p1_v, p2_v;
    logic [31:0] p1_x, p2_x;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_sat = 0; m_drop = 0; m_ovf = 0;
            p1_v = 0; p2_v = 0; p1_x = '0; p2_x = '0;
        end else begin
            bit          was_full, pop;
            logic [16:0] s;
            was_full = (mq.size() == 8);
            pop      = (mq.size() != 0) && out_ready;
            if (pop) void'(mq.pop_front());
            if (p2_v) begin
                s = model_sample(p2_x);
                if (s[16]) begin
                    if (m_sat < 65535) m_sat++;
                    m_ovf = 1;
                end
                if (was_full && !pop) begin
                    if (m_drop < 65535) m_drop++;
                    m_ovf = 1;
                end else begin
                    mq.push_back(s[15:0]);
                end
            end
            if (clr_stats) begin
                m_sat = 0; m_drop = 0; m_ovf = 0;
            end
            p2_v = p1_v; p2_x = p1_x;
            p1_v = in_valid; p1_x = in_data;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        check("model out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) check("model out_data", 32'(out_data), 32'(mq[0]));
        check("model level", 32'(level), 32'(mq.size()));
        check("model sat_cnt", 32'(sat_cnt), 32'(m_sat));
        check("model drop_cnt", 32'(drop_cnt), 32'(m_drop));
        check("model ovf_sticky", 32'(ovf_sticky), 32'(m_ovf));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rvals [4];
        logic [15:0] rexp  [4];
        rvals[0] = 32'd64;  rvals[1] = 32'd63;  rvals[2] = -32'sd64; rvals[3] = -32'sd65;
        rexp[0]  = 16'h0001; rexp[1] = 16'h0000; rexp[2] = 16'h0000;  rexp[3] = 16'hFFFF;

        reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_stats = 1'b0;
        #1 reset = 1'b1;
        step(); step();
        reset = 1'b0;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset level", 32'(level), 32'd0);
        check("reset sat_cnt", 32'(sat_cnt), 32'd0);
        check("reset drop_cnt", 32'(drop_cnt), 32'd0);
        check("reset ovf", 32'(ovf_sticky), 32'd0);

        // Rounding: 64,63,-64,-65 -> 1,0,0,-1, each 3 edges after input.
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = (i < 4);
            in_data  = (i < 4) ? rvals[i] : 32'd0;
            step();
            if (i == 1) check("round latency", 32'(out_valid), 32'd0);
            if (i >= 2 && i <= 5) check("round data", 32'(out_data), 32'(rexp[i-2]));
            if (i == 6) check("round drained", 32'(out_valid), 32'd0);
        end
        check("round sat_cnt", 32'(sat_cnt), 32'd0);

        // Saturation both ways.
        in_valid = 1'b1; in_data = 32'h0040_0000; step();
        in_data = 32'hFF00_0000; step();
        in_valid = 1'b0; step();
        check("sat pos", 32'(out_data), 32'h7FFF);
        step();
        check("sat neg", 32'(out_data), 32'h8000);
        step();
        check("sat count", 32'(sat_cnt), 32'd2);
        check("sat ovf", 32'(ovf_sticky), 32'd1);

        // Overflow: 10 samples into a stalled FIFO.
        out_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            in_valid = 1'b1; in_data = 32'(k * 128); step();
        end
        in_valid = 1'b0; step(); step();
        check("ovf level", 32'(level), 32'd8);
        check("ovf drop_cnt", 32'(drop_cnt), 32'd2);
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            check("ovf read valid", 32'(out_valid), 32'd1);
            check("ovf read data", 32'(out_data), 32'(k));
            step();
        end
        check("ovf emptied", 32'(out_valid), 32'd0);

        // Full with simultaneous pop.
        out_ready = 1'b0;
        for (int k = 11; k <= 18; k++) begin
            in_valid = 1'b1; in_data = 32'(k * 128); step();
        end
        in_valid = 1'b0; step(); step();
        check("full level", 32'(level), 32'd8);
        in_valid = 1'b1; in_data = 32'(19 * 128); step();
        in_valid = 1'b0; step();
        out_ready = 1'b1; step();
        out_ready = 1'b0;
        check("full+pop level", 32'(level), 32'd8);
        check("full+pop drop_cnt", 32'(drop_cnt), 32'd2);
        out_ready = 1'b1;
        for (int k = 12; k <= 19; k++) begin
            check("full+pop data", 32'(out_data), 32'(k));
            step();
        end
        check("full+pop emptied", 32'(out_valid), 32'd0);

        // clr_stats on the same edge as a saturating write.
        in_valid = 1'b1; in_data = 32'h0040_0000; step();
        in_valid = 1'b0; step();
        clr_stats = 1'b1; step();
        clr_stats = 1'b0;
        check("clr sat_cnt", 32'(sat_cnt), 32'd0);
        check("clr ovf", 32'(ovf_sticky), 32'd0);
        check("clr keeps data", 32'(out_data), 32'h7FFF);
        step(); step();

        // Asynchronous reset with samples in flight.
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1; in_data = 32'(k * 128); step();
        end
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst level", 32'(level), 32'd0);
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        in_valid = 1'b1; in_data = 32'd640; step();
        in_valid = 1'b0; step();
        check("post rst early", 32'(out_valid), 32'd0);
        step();
        check("post rst valid", 32'(out_valid), 32'd1);
        check("post rst data", 32'(out_data), 32'd5);
        check("post rst level", 32'(level), 32'd1);
        out_ready = 1'b1; step();
        check("post rst no stale", 32'(out_valid), 32'd0);
        step(); step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
